// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle between axil_master (master modport) and a slave (slave modport).
interface axil_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns one local command at a time into an AW/W/B or AR/R transaction.
// Defining AXIL_MASTER_TIMEOUT_EN adds a response watchdog with a DRAIN state.
module axil_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  axil_master_if.master         axi
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
`ifdef AXIL_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;

  state_t                state, state_n;
  logic                  awvalid, awvalid_n, wvalid, wvalid_n, bready, bready_n;
  logic                  arvalid, arvalid_n, rready, rready_n;
  logic                  aw_done, aw_done_n, w_done, w_done_n, op_write, op_write_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] wdata, wdata_n, rsp_rdata_n;
  logic [STRB_WIDTH-1:0] wstrb, wstrb_n;
  logic                  cmd_ready_n, rsp_valid_n, rsp_write_n;
  logic [1:0]            rsp_resp_n;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("axil_master: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tmo, tmo_n;
`endif

  assign axi.AWADDR  = addr;
  assign axi.AWPROT  = 3'b000;
  assign axi.AWVALID = awvalid;
  assign axi.WDATA   = wdata;
  assign axi.WSTRB   = wstrb;
  assign axi.WVALID  = wvalid;
  assign axi.BREADY  = bready;
  assign axi.ARADDR  = addr;
  assign axi.ARPROT  = 3'b000;
  assign axi.ARVALID = arvalid;
  assign axi.RREADY  = rready;

  assign aw_hs = awvalid & axi.AWREADY;
  assign w_hs  = wvalid  & axi.WREADY;
  assign b_hs  = bready  & axi.BVALID;
  assign ar_hs = arvalid & axi.ARREADY;
  assign r_hs  = rready  & axi.RVALID;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_n     = state;
    cmd_ready_n = 1'b0;
    awvalid_n   = awvalid;
    wvalid_n    = wvalid;
    bready_n    = bready;
    arvalid_n   = arvalid;
    rready_n    = rready;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    op_write_n  = op_write;
    addr_n      = addr;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    rsp_valid_n = 1'b0;
    rsp_write_n = rsp_write;
    rsp_resp_n  = rsp_resp;
    rsp_rdata_n = rsp_rdata;

    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          op_write_n  = cmd_write;
          addr_n      = cmd_addr;
          aw_done_n   = 1'b0;
          w_done_n    = 1'b0;
          if (cmd_write) begin
            wdata_n   = cmd_wdata;
            wstrb_n   = cmd_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_REQ;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_write_n = op_write;
          rsp_resp_n  = axi.BRESP;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_write_n = op_write;
          rsp_resp_n  = axi.RRESP;
          rsp_rdata_n = axi.RDATA;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      DRAIN: begin
        if (b_hs || r_hs) begin
          bready_n    = 1'b0;
          rready_n    = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    // A timed-out transaction still finishes its handshakes, but its late response is swallowed in DRAIN.
    cnt_n = cnt;
    tmo_n = tmo;
    if (state == IDLE) begin
      cnt_n = '0;
      tmo_n = 1'b0;
    end else if (aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
      cnt_n = '0;
    end else if (state != DRAIN && !tmo) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_n       = 1'b1;
        rsp_valid_n = 1'b1;
        rsp_write_n = op_write;
        rsp_resp_n  = 2'b11;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
    if (tmo_n && (state_n == WR_RESP || state_n == RD_RESP)) state_n = DRAIN;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      op_write  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt       <= '0;
      tmo       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      awvalid   <= awvalid_n;
      wvalid    <= wvalid_n;
      bready    <= bready_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      op_write  <= op_write_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      rsp_valid <= rsp_valid_n;
      rsp_write <= rsp_write_n;
      rsp_resp  <= rsp_resp_n;
      rsp_rdata <= rsp_rdata_n;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt       <= cnt_n;
      tmo       <= tmo_n;
`endif
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed self-checking bench for axil_master; inputs change and outputs are sampled on negedge.
// The watchdog scenario runs only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  axil_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

  axil_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .STRB_WIDTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_write(rsp_write),
    .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata),
    .axi(axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 8'h00;
    cmd_wdata   = 32'h0;
    cmd_wstrb   = 4'h0;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    axi.ARREADY = 1'b1;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.RVALID  = 1'b0;
    axi.RDATA   = 32'h0;
    axi.RRESP   = 2'b00;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_write", 32'(rsp_write), 32'd0);
    checkOutput("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_awvalid", 32'(axi.AWVALID), 32'd0);
    checkOutput("rst_wvalid", 32'(axi.WVALID), 32'd0);
    checkOutput("rst_arvalid", 32'(axi.ARVALID), 32'd0);
    checkOutput("rst_bready", 32'(axi.BREADY), 32'd0);
    checkOutput("rst_rready", 32'(axi.RREADY), 32'd0);
    checkOutput("rst_awaddr", 32'(axi.AWADDR), 32'd0);
    checkOutput("rst_wdata", axi.WDATA, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write 0x28 <= 0xDEADBEEF
    applyStimulus(1'b1, 8'h28, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checkOutput("t1_awvalid", 32'(axi.AWVALID), 32'd1);
    checkOutput("t1_wvalid", 32'(axi.WVALID), 32'd1);
    checkOutput("t1_awaddr", 32'(axi.AWADDR), 32'h28);
    checkOutput("t1_wdata", axi.WDATA, 32'hDEADBEEF);
    checkOutput("t1_wstrb", 32'(axi.WSTRB), 32'hF);
    checkOutput("t1_awprot", 32'(axi.AWPROT), 32'd0);
    checkOutput("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    checkOutput("t1_bready_early", 32'(axi.BREADY), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_awvalid_drop", 32'(axi.AWVALID), 32'd0);
    checkOutput("t1_wvalid_drop", 32'(axi.WVALID), 32'd0);
    checkOutput("t1_bready", 32'(axi.BREADY), 32'd1);
    checkOutput("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b00;
    @(negedge clk);
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t1_rsp_write", 32'(rsp_write), 32'd1);
    checkOutput("t1_rsp_resp", 32'(rsp_resp), 32'd0);
    checkOutput("t1_cmd_ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("t1_bready_off", 32'(axi.BREADY), 32'd0);
    axi.BVALID = 1'b0;

    // Back-to-back read of 0x28 returning 0xDEADBEEF
    applyStimulus(1'b0, 8'h28, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t2_rsp_pulse_end", 32'(rsp_valid), 32'd0);
    checkOutput("t2_arvalid", 32'(axi.ARVALID), 32'd1);
    checkOutput("t2_araddr", 32'(axi.ARADDR), 32'h28);
    checkOutput("t2_arprot", 32'(axi.ARPROT), 32'd0);
    checkOutput("t2_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_arvalid_drop", 32'(axi.ARVALID), 32'd0);
    checkOutput("t2_rready", 32'(axi.RREADY), 32'd1);
    axi.RVALID = 1'b1;
    axi.RDATA  = 32'hDEADBEEF;
    axi.RRESP  = 2'b00;
    @(negedge clk);
    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t2_rsp_write", 32'(rsp_write), 32'd0);
    checkOutput("t2_rsp_resp", 32'(rsp_resp), 32'd0);
    checkOutput("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("t2_rready_off", 32'(axi.RREADY), 32'd0);
    axi.RVALID = 1'b0;
    axi.RDATA  = 32'h0;
    @(negedge clk);
    checkOutput("t2_rsp_one_cycle", 32'(rsp_valid), 32'd0);

    // Write with AWREADY one cycle after VALID, WREADY four cycles after
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    applyStimulus(1'b1, 8'h44, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    checkOutput("t3_awvalid", 32'(axi.AWVALID), 32'd1);
    checkOutput("t3_wvalid", 32'(axi.WVALID), 32'd1);
    cmd_valid   = 1'b0;
    axi.AWREADY = 1'b1;
    @(negedge clk);
    checkOutput("t3_awvalid_drop", 32'(axi.AWVALID), 32'd0);
    checkOutput("t3_wvalid_held1", 32'(axi.WVALID), 32'd1);
    checkOutput("t3_bready_wait", 32'(axi.BREADY), 32'd0);
    axi.AWREADY = 1'b0;
    @(negedge clk);
    checkOutput("t3_wvalid_held2", 32'(axi.WVALID), 32'd1);
    checkOutput("t3_wdata_stable", axi.WDATA, 32'h0BADF00D);
    @(negedge clk);
    checkOutput("t3_wvalid_held3", 32'(axi.WVALID), 32'd1);
    checkOutput("t3_awvalid_stays", 32'(axi.AWVALID), 32'd0);
    axi.WREADY = 1'b1;
    @(negedge clk);
    checkOutput("t3_wvalid_drop", 32'(axi.WVALID), 32'd0);
    checkOutput("t3_bready", 32'(axi.BREADY), 32'd1);
    axi.WREADY = 1'b0;
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b00;
    @(negedge clk);
    checkOutput("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t3_rsp_write", 32'(rsp_write), 32'd1);
    checkOutput("t3_rdata_kept", rsp_rdata, 32'hDEADBEEF);
    axi.BVALID = 1'b0;
    @(negedge clk);
    checkOutput("t3_single_rsp", 32'(rsp_valid), 32'd0);
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;

    // Partial-strobe write with SLVERR, then read of 0xFC with DECERR
    applyStimulus(1'b1, 8'h00, 32'h12345678, 4'b0101);
    @(negedge clk);
    checkOutput("t4_wstrb", 32'(axi.WSTRB), 32'h5);
    checkOutput("t4_awaddr", 32'(axi.AWADDR), 32'h00);
    checkOutput("t4_wdata", axi.WDATA, 32'h12345678);
    cmd_valid = 1'b0;
    @(negedge clk);
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b10;
    @(negedge clk);
    checkOutput("t4_wr_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t4_wr_slverr", 32'(rsp_resp), 32'h2);
    axi.BVALID = 1'b0;
    axi.BRESP  = 2'b00;
    applyStimulus(1'b0, 8'hFC, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t4_araddr", 32'(axi.ARADDR), 32'hFC);
    cmd_valid = 1'b0;
    @(negedge clk);
    axi.RVALID = 1'b1;
    axi.RDATA  = 32'hCAFEF00D;
    axi.RRESP  = 2'b11;
    @(negedge clk);
    checkOutput("t4_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t4_rd_decerr", 32'(rsp_resp), 32'h3);
    checkOutput("t4_rd_rdata", rsp_rdata, 32'hCAFEF00D);
    checkOutput("t4_rd_write", 32'(rsp_write), 32'd0);
    axi.RVALID = 1'b0;
    axi.RRESP  = 2'b00;
    @(negedge clk);

    // Reset while waiting in RD_RESP with RVALID withheld
    applyStimulus(1'b0, 8'h10, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t5_arvalid", 32'(axi.ARVALID), 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_rready", 32'(axi.RREADY), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_arvalid_rst", 32'(axi.ARVALID), 32'd0);
    checkOutput("t5_rready_rst", 32'(axi.RREADY), 32'd0);
    checkOutput("t5_no_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("t5_cmd_ready_rst", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_cmd_ready_after", 32'(cmd_ready), 32'd1);
    checkOutput("t5_no_rsp_after", 32'(rsp_valid), 32'd0);

    // Reset while AWVALID/WVALID are stalled
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    applyStimulus(1'b1, 8'h20, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    checkOutput("t5w_awvalid", 32'(axi.AWVALID), 32'd1);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    checkOutput("t5w_awvalid_rst", 32'(axi.AWVALID), 32'd0);
    checkOutput("t5w_wvalid_rst", 32'(axi.WVALID), 32'd0);
    reset       = 1'b0;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    @(negedge clk);
    checkOutput("t5w_cmd_ready_after", 32'(cmd_ready), 32'd1);
    checkOutput("t5w_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Watchdog: BVALID withheld for 40 cycles, timeout after 16 cycles in WR_RESP
    begin : t6
      int tmoAt;
      int extraRsp;
      tmoAt    = 0;
      extraRsp = 0;
      applyStimulus(1'b1, 8'h80, 32'h55AA55AA, 4'hF);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 2; k <= 40; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          if (tmoAt == 0) begin
            tmoAt = k;
            checkOutput("t6_tmo_resp", 32'(rsp_resp), 32'h3);
            checkOutput("t6_tmo_write", 32'(rsp_write), 32'd1);
            checkOutput("t6_tmo_rdata_kept", rsp_rdata, 32'd0);
          end else begin
            extraRsp++;
          end
        end
      end
      checkOutput("t6_tmo_cycle", 32'(tmoAt), 32'd18);
      checkOutput("t6_drain_bready", 32'(axi.BREADY), 32'd1);
      checkOutput("t6_drain_busy", 32'(cmd_ready), 32'd0);
      axi.BVALID = 1'b1;
      axi.BRESP  = 2'b00;
      @(negedge clk);
      checkOutput("t6_late_b_silent", 32'(rsp_valid), 32'd0);
      checkOutput("t6_bready_off", 32'(axi.BREADY), 32'd0);
      checkOutput("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("t6_extra_rsp", 32'(extraRsp), 32'd0);
      axi.BVALID = 1'b0;
      applyStimulus(1'b0, 8'h28, 32'h0, 4'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      axi.RVALID = 1'b1;
      axi.RDATA  = 32'h600DCAFE;
      axi.RRESP  = 2'b00;
      @(negedge clk);
      checkOutput("t6_next_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t6_next_resp", 32'(rsp_resp), 32'd0);
      checkOutput("t6_next_rdata", rsp_rdata, 32'h600DCAFE);
      axi.RVALID = 1'b0;
    end
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
